// File: rtl/core_alu_arbiter.sv
// core_alu_arbiter
//   Shares one registered integer ALU between two requesters: req0 is the
//   execute stage and req1 is the load/store address generator. Arbitration
//   is round-robin. A request is granted only when its response FIFO has a
//   free slot, counting the result that is still in flight in the ALU.
//   Results return in request order, with a fixed latency of two cycles.
//
// Optional feature: define CORE_ALU_ARB_PERF_EN to add saturating perf
//   counters (o_perf_grant0, o_perf_grant1, o_perf_conflict).
//
// Ports:
//   i_clk, i_rst_n                  clock, async active-low reset
//   i_reqN_valid / o_reqN_ready     request handshake (N = 0,1)
//   i_reqN_op/rs1/rs2/imm           op index and operands
//   o_respN_valid / i_respN_ready   response FIFO head handshake
//   o_respN_data                    response FIFO head (0 when empty)
//   o_alu_op                        one-hot op strobes to the ALU
//   o_alu_rs1/rs2/imm               operands to the ALU
//   i_alu_result                    registered ALU result (one cycle later)
module core_alu_arbiter #(
  parameter int unsigned NOPS       = 35,
  parameter int unsigned OPW        = 6,
  parameter int unsigned RESP_DEPTH = 3
) (
  input  logic            i_clk,
  input  logic            i_rst_n,
  input  logic            i_req0_valid,
  output logic            o_req0_ready,
  input  logic [OPW-1:0]  i_req0_op,
  input  logic [31:0]     i_req0_rs1,
  input  logic [31:0]     i_req0_rs2,
  input  logic [31:0]     i_req0_imm,
  input  logic            i_req1_valid,
  output logic            o_req1_ready,
  input  logic [OPW-1:0]  i_req1_op,
  input  logic [31:0]     i_req1_rs1,
  input  logic [31:0]     i_req1_rs2,
  input  logic [31:0]     i_req1_imm,
  output logic            o_resp0_valid,
  input  logic            i_resp0_ready,
  output logic [31:0]     o_resp0_data,
  output logic            o_resp1_valid,
  input  logic            i_resp1_ready,
  output logic [31:0]     o_resp1_data,
  output logic [NOPS-1:0] o_alu_op,
  output logic [31:0]     o_alu_rs1,
  output logic [31:0]     o_alu_rs2,
  output logic [31:0]     o_alu_imm,
`ifdef CORE_ALU_ARB_PERF_EN
  output logic [31:0]     o_perf_grant0,
  output logic [31:0]     o_perf_grant1,
  output logic [31:0]     o_perf_conflict,
`endif
  input  logic [31:0]     i_alu_result
);

  localparam int unsigned PW  = (RESP_DEPTH > 1) ? $clog2(RESP_DEPTH) : 1;
  localparam int unsigned CW  = $clog2(RESP_DEPTH + 1);
  localparam int unsigned OCW = CW + 1;

  // Response FIFOs, one per requester
  logic [31:0]   r_mem [2][RESP_DEPTH];
  logic [PW-1:0] r_wr  [2];
  logic [PW-1:0] r_rd  [2];
  logic [CW-1:0] r_cnt [2];

  // ALU ownership of the result arriving next cycle, plus round-robin pointer
  logic r_inflight_valid;
  logic r_inflight_id;
  logic r_ptr;

  logic [OCW-1:0] w_occ [2];
  logic [1:0]     w_elig;
  logic [1:0]     w_ready;
  logic [1:0]     w_gnt;
  logic [1:0]     w_push;
  logic [1:0]     w_pop;
  logic [1:0]     w_resp_ready;
  logic [OPW-1:0] w_op;

  function automatic logic [PW-1:0] f_inc(input logic [PW-1:0] p);
    return (p == PW'(RESP_DEPTH - 1)) ? '0 : p + PW'(1);
  endfunction

  assign w_resp_ready = {i_resp1_ready, i_resp0_ready};

  // Occupancy counts the in-flight result so a push always finds room
  always_comb begin
    for (int n = 0; n < 2; n++) begin
      w_occ[n]  = OCW'(r_cnt[n]) +
                  OCW'(r_inflight_valid && (r_inflight_id == 1'(n)));
      w_elig[n] = (w_occ[n] < OCW'(RESP_DEPTH));
      w_push[n] = r_inflight_valid && (r_inflight_id == 1'(n));
      w_pop[n]  = (r_cnt[n] != '0) && w_resp_ready[n];
    end
  end

  // Round-robin ready; the pointer only matters when both could be served
  assign w_ready[0] = i_rst_n && w_elig[0] &&
                      (!(i_req1_valid && w_elig[1]) || (r_ptr == 1'b0));
  assign w_ready[1] = i_rst_n && w_elig[1] &&
                      (!(i_req0_valid && w_elig[0]) || (r_ptr == 1'b1));
  assign w_gnt      = w_ready & {i_req1_valid, i_req0_valid};

  assign o_req0_ready = w_ready[0];
  assign o_req1_ready = w_ready[1];

  // ALU drive: grant mux; out-of-range ops produce no strobe
  always_comb begin
    o_alu_op  = '0;
    o_alu_rs1 = '0;
    o_alu_rs2 = '0;
    o_alu_imm = '0;
    w_op      = w_gnt[1] ? i_req1_op : i_req0_op;
    if (w_gnt[0]) begin
      o_alu_rs1 = i_req0_rs1;
      o_alu_rs2 = i_req0_rs2;
      o_alu_imm = i_req0_imm;
    end else if (w_gnt[1]) begin
      o_alu_rs1 = i_req1_rs1;
      o_alu_rs2 = i_req1_rs2;
      o_alu_imm = i_req1_imm;
    end
    if ((|w_gnt) && (32'(w_op) < 32'(NOPS))) begin
      o_alu_op = NOPS'(1) << w_op;
    end
  end

  // Grant tracking and round-robin update
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_inflight_valid <= 1'b0;
      r_inflight_id    <= 1'b0;
      r_ptr            <= 1'b0;
    end else begin
      r_inflight_valid <= |w_gnt;
      if (|w_gnt) begin
        r_inflight_id <= w_gnt[1];
        r_ptr         <= ~w_gnt[1];
      end
    end
  end

  // Response FIFOs: push ALU result for the owner, pop on consumer handshake
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      for (int n = 0; n < 2; n++) begin
        r_wr[n]  <= '0;
        r_rd[n]  <= '0;
        r_cnt[n] <= '0;
        for (int k = 0; k < RESP_DEPTH; k++) begin
          r_mem[n][k] <= '0;
        end
      end
    end else begin
      for (int n = 0; n < 2; n++) begin
        if (w_push[n]) begin
          r_mem[n][r_wr[n]] <= i_alu_result;
          r_wr[n]           <= f_inc(r_wr[n]);
        end
        if (w_pop[n]) begin
          r_rd[n] <= f_inc(r_rd[n]);
        end
        case ({w_push[n], w_pop[n]})
          2'b10:   r_cnt[n] <= r_cnt[n] + CW'(1);
          2'b01:   r_cnt[n] <= r_cnt[n] - CW'(1);
          default: r_cnt[n] <= r_cnt[n];
        endcase
      end
    end
  end

  assign o_resp0_valid = (r_cnt[0] != '0);
  assign o_resp1_valid = (r_cnt[1] != '0);
  assign o_resp0_data  = o_resp0_valid ? r_mem[0][r_rd[0]] : '0;
  assign o_resp1_data  = o_resp1_valid ? r_mem[1][r_rd[1]] : '0;

`ifdef CORE_ALU_ARB_PERF_EN
  logic [31:0] r_perf_grant0;
  logic [31:0] r_perf_grant1;
  logic [31:0] r_perf_conflict;
  logic        w_conflict;

  assign w_conflict = i_req0_valid && i_req1_valid && w_elig[0] && w_elig[1];

  // Saturating event counters
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_perf_grant0   <= '0;
      r_perf_grant1   <= '0;
      r_perf_conflict <= '0;
    end else begin
      if (w_gnt[0] && (r_perf_grant0 != 32'hFFFF_FFFF)) begin
        r_perf_grant0 <= r_perf_grant0 + 32'd1;
      end
      if (w_gnt[1] && (r_perf_grant1 != 32'hFFFF_FFFF)) begin
        r_perf_grant1 <= r_perf_grant1 + 32'd1;
      end
      if (w_conflict && (r_perf_conflict != 32'hFFFF_FFFF)) begin
        r_perf_conflict <= r_perf_conflict + 32'd1;
      end
    end
  end

  assign o_perf_grant0   = r_perf_grant0;
  assign o_perf_grant1   = r_perf_grant1;
  assign o_perf_conflict = r_perf_conflict;
`endif

endmodule

// File: tb/tb_core_alu_arbiter.sv
// Testbench for core_alu_arbiter: behavioural registered ALU, scoreboard
// queues per requester filled at request handshake and drained at response
// handshake, plus directed scenario tasks.
`timescale 1ns/1ps
module tb_core_alu_arbiter;

  logic        clk;
  logic        rst_n;
  logic        req0_valid, req1_valid;
  logic        req0_ready, req1_ready;
  logic [5:0]  req0_op, req1_op;
  logic [31:0] req0_rs1, req0_rs2, req0_imm;
  logic [31:0] req1_rs1, req1_rs2, req1_imm;
  logic        resp0_valid, resp1_valid;
  logic        resp0_ready, resp1_ready;
  logic [31:0] resp0_data, resp1_data;
  logic [34:0] alu_op;
  logic [31:0] alu_rs1, alu_rs2, alu_imm;
  logic [31:0] alu_result;
`ifdef CORE_ALU_ARB_PERF_EN
  logic [31:0] perf_grant0, perf_grant1, perf_conflict;
`endif

  int n_checks = 0;
  int n_errors = 0;

  logic [31:0] q0[$];
  logic [31:0] q1[$];
  logic [31:0] exp_v;

  core_alu_arbiter dut (
    .i_clk        (clk),
    .i_rst_n      (rst_n),
    .i_req0_valid (req0_valid),
    .o_req0_ready (req0_ready),
    .i_req0_op    (req0_op),
    .i_req0_rs1   (req0_rs1),
    .i_req0_rs2   (req0_rs2),
    .i_req0_imm   (req0_imm),
    .i_req1_valid (req1_valid),
    .o_req1_ready (req1_ready),
    .i_req1_op    (req1_op),
    .i_req1_rs1   (req1_rs1),
    .i_req1_rs2   (req1_rs2),
    .i_req1_imm   (req1_imm),
    .o_resp0_valid(resp0_valid),
    .i_resp0_ready(resp0_ready),
    .o_resp0_data (resp0_data),
    .o_resp1_valid(resp1_valid),
    .i_resp1_ready(resp1_ready),
    .o_resp1_data (resp1_data),
    .o_alu_op     (alu_op),
    .o_alu_rs1    (alu_rs1),
    .o_alu_rs2    (alu_rs2),
    .o_alu_imm    (alu_imm),
`ifdef CORE_ALU_ARB_PERF_EN
    .o_perf_grant0  (perf_grant0),
    .o_perf_grant1  (perf_grant1),
    .o_perf_conflict(perf_conflict),
`endif
    .i_alu_result (alu_result)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic [31:0] f_model(input logic [5:0] op, input logic [31:0] a,
                                          input logic [31:0] b, input logic [31:0] imm);
    case (op)
      6'd0:         return a + imm;
      6'd9:         return a + b;
      6'd10:        return a - b;
      6'd14:        return a ^ b;
      6'd27, 6'd32: return a + imm;
      default:      return 32'd0;
    endcase
  endfunction

  function automatic logic [34:0] f_onehot(input logic [5:0] op);
    logic [34:0] r;
    r = '0;
    if (op < 6'd35) r[op] = 1'b1;
    return r;
  endfunction

  function automatic logic [5:0] f_decode(input logic [34:0] oh);
    logic [5:0] r;
    r = 6'd63;
    for (int k = 0; k < 35; k++) if (oh[k]) r = 6'(k);
    return r;
  endfunction

  // External registered ALU
  always @(posedge clk) begin
    alu_result <= f_model(f_decode(alu_op), alu_rs1, alu_rs2, alu_imm);
  end

  // Scoreboard: push on request handshake, compare on response handshake
  always @(negedge clk) begin
    if (!rst_n) begin
      q0.delete();
      q1.delete();
    end else begin
      if (req0_valid && req0_ready) begin
        q0.push_back(f_model(req0_op, req0_rs1, req0_rs2, req0_imm));
        n_checks++;
        if (alu_op !== f_onehot(req0_op)) begin
          n_errors++;
          $display("FAIL sb_alu_op0 got=%h exp=%h", alu_op, f_onehot(req0_op));
        end
      end
      if (req1_valid && req1_ready) begin
        q1.push_back(f_model(req1_op, req1_rs1, req1_rs2, req1_imm));
        n_checks++;
        if (alu_op !== f_onehot(req1_op)) begin
          n_errors++;
          $display("FAIL sb_alu_op1 got=%h exp=%h", alu_op, f_onehot(req1_op));
        end
      end
      if (resp0_valid && resp0_ready) begin
        n_checks++;
        if (q0.size() == 0) begin
          n_errors++;
          $display("FAIL sb_resp0_unexpected got=%h exp=none", resp0_data);
        end else begin
          exp_v = q0.pop_front();
          if (resp0_data !== exp_v) begin
            n_errors++;
            $display("FAIL sb_resp0_data got=%h exp=%h", resp0_data, exp_v);
          end
        end
      end
      if (resp1_valid && resp1_ready) begin
        n_checks++;
        if (q1.size() == 0) begin
          n_errors++;
          $display("FAIL sb_resp1_unexpected got=%h exp=none", resp1_data);
        end else begin
          exp_v = q1.pop_front();
          if (resp1_data !== exp_v) begin
            n_errors++;
            $display("FAIL sb_resp1_data got=%h exp=%h", resp1_data, exp_v);
          end
        end
      end
    end
  end

  task automatic do_reset();
    rst_n      = 1'b0;
    req0_valid = 1'b0;
    req1_valid = 1'b0;
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    req0_valid = 1'b1; req0_op = 6'd9; req0_rs1 = 1; req0_rs2 = 2; req0_imm = 0;
    req1_valid = 1'b1; req1_op = 6'd9; req1_rs1 = 1; req1_rs2 = 2; req1_imm = 0;
    resp0_ready = 1'b1; resp1_ready = 1'b1;
    repeat (2) @(posedge clk);
    @(negedge clk);
    n_checks++;
    if ({req0_ready, req1_ready} !== 2'b00) begin
      n_errors++; $display("FAIL reset_ready got=%b exp=00", {req0_ready, req1_ready});
    end
    n_checks++;
    if ({resp0_valid, resp1_valid} !== 2'b00) begin
      n_errors++; $display("FAIL reset_resp_valid got=%b exp=00", {resp0_valid, resp1_valid});
    end
    n_checks++;
    if ((resp0_data !== 32'd0) || (resp1_data !== 32'd0)) begin
      n_errors++; $display("FAIL reset_resp_data got=%h/%h exp=0", resp0_data, resp1_data);
    end
    n_checks++;
    if ((alu_op !== '0) || (alu_rs1 !== 32'd0) || (alu_rs2 !== 32'd0) || (alu_imm !== 32'd0)) begin
      n_errors++; $display("FAIL reset_alu got=%h/%h exp=0", alu_op, alu_rs1);
    end
    req0_valid = 1'b0; req1_valid = 1'b0;
    @(posedge clk);
    #1 rst_n = 1'b1;
    @(posedge clk); #1;
  endtask

  task automatic test_single();
    logic [34:0] e;
    e = '0; e[9] = 1'b1;
    req0_valid = 1'b1; req0_op = 6'd9; req0_rs1 = 5; req0_rs2 = 7; req0_imm = 0;
    @(negedge clk);
    n_checks++;
    if ((alu_op !== e) || (req0_ready !== 1'b1)) begin
      n_errors++; $display("FAIL single_grant got=%h rdy=%b exp=%h rdy=1", alu_op, req0_ready, e);
    end
    @(posedge clk); #1 req0_valid = 1'b0;
    @(negedge clk);
    n_checks++;
    if ((alu_op !== '0) || (resp0_valid !== 1'b0)) begin
      n_errors++; $display("FAIL single_cycle1 got=%h v=%b exp=0 v=0", alu_op, resp0_valid);
    end
    @(posedge clk); #1;
    @(negedge clk);
    n_checks++;
    if ((resp0_valid !== 1'b1) || (resp0_data !== 32'd12)) begin
      n_errors++; $display("FAIL single_resp got=%b/%0d exp=1/12", resp0_valid, resp0_data);
    end
    @(posedge clk); #1;
  endtask

  task automatic test_contention();
    do_reset();
    req0_op = 6'd0; req0_imm = 1; req0_rs2 = 0; req0_rs1 = 100;
    req1_op = 6'd10; req1_rs1 = 10; req1_rs2 = 3; req1_imm = 0;
    req0_valid = 1'b1; req1_valid = 1'b1;
    for (int k = 0; k < 8; k++) begin
      @(negedge clk);
      n_checks++;
      if ({req1_ready, req0_ready} !== ((k % 2 == 0) ? 2'b01 : 2'b10)) begin
        n_errors++; $display("FAIL contention_grant cyc=%0d got=%b exp=%b", k,
                             {req1_ready, req0_ready}, (k % 2 == 0) ? 2'b01 : 2'b10);
      end
      @(posedge clk); #1 req0_rs1 = 32'(100 + 3 * (k + 1));
    end
    req0_valid = 1'b0; req1_valid = 1'b0;
    repeat (3) @(posedge clk);
    #1;
  endtask

  task automatic test_backpressure();
    int acc;
    logic [31:0] exp_d [3];
    exp_d[0] = 32'h1004; exp_d[1] = 32'h1008; exp_d[2] = 32'h100C;
    acc = 0;
    resp1_ready = 1'b0;
    req1_valid = 1'b1; req1_op = 6'd32; req1_rs1 = 32'h1000; req1_rs2 = 0; req1_imm = 4;
    for (int c = 0; c < 6; c++) begin
      @(negedge clk);
      if (req1_ready) acc++;
      @(posedge clk); #1 req1_imm = 32'(4 * (acc + 1));
    end
    n_checks++;
    if (acc != 3) begin
      n_errors++; $display("FAIL bp_accepted got=%0d exp=3", acc);
    end
    n_checks++;
    if (req1_ready !== 1'b0) begin
      n_errors++; $display("FAIL bp_ready_low got=%b exp=0", req1_ready);
    end
    req1_valid = 1'b0; resp1_ready = 1'b1;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      n_checks++;
      if ((resp1_valid !== 1'b1) || (resp1_data !== exp_d[i])) begin
        n_errors++; $display("FAIL bp_drain%0d got=%b/%h exp=1/%h", i, resp1_valid, resp1_data, exp_d[i]);
      end
      @(posedge clk); #1;
    end
    @(negedge clk);
    n_checks++;
    if ((resp1_valid !== 1'b0) || (req1_ready !== 1'b1)) begin
      n_errors++; $display("FAIL bp_after got=v%b r%b exp=v0 r1", resp1_valid, req1_ready);
    end
    @(posedge clk); #1;
  endtask

  task automatic test_illegal();
    req0_valid = 1'b1; req0_op = 6'd40; req0_rs1 = 5; req0_rs2 = 5; req0_imm = 5;
    @(negedge clk);
    n_checks++;
    if ((alu_op !== '0) || (req0_ready !== 1'b1)) begin
      n_errors++; $display("FAIL illegal_op got=%h rdy=%b exp=0 rdy=1", alu_op, req0_ready);
    end
    @(posedge clk); #1 req0_valid = 1'b0;
    @(posedge clk); #1;
    @(negedge clk);
    n_checks++;
    if ((resp0_valid !== 1'b1) || (resp0_data !== 32'd0)) begin
      n_errors++; $display("FAIL illegal_resp got=%b/%h exp=1/0", resp0_valid, resp0_data);
    end
    @(posedge clk); #1;
  endtask

  task automatic test_reset_midflight();
    resp0_ready = 1'b0;
    req0_valid = 1'b1; req0_op = 6'd9; req0_rs1 = 1; req0_rs2 = 2; req0_imm = 0;
    repeat (2) @(posedge clk);
    #1 req0_valid = 1'b0;
    n_checks++;
    if (resp0_valid !== 1'b1) begin
      n_errors++; $display("FAIL mid_pre got=%b exp=1", resp0_valid);
    end
    rst_n = 1'b0;
    #1;
    n_checks++;
    if ((resp0_valid !== 1'b0) || (resp0_data !== 32'd0) || (req0_ready !== 1'b0)) begin
      n_errors++; $display("FAIL mid_reset got=v%b d%h r%b exp=v0 d0 r0", resp0_valid, resp0_data, req0_ready);
    end
    @(posedge clk); #1 rst_n = 1'b1; resp0_ready = 1'b1;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      n_checks++;
      if (resp0_valid !== 1'b0) begin
        n_errors++; $display("FAIL mid_after%0d got=%b exp=0", i, resp0_valid);
      end
      @(posedge clk); #1;
    end
  endtask

`ifdef CORE_ALU_ARB_PERF_EN
  task automatic test_perf();
    do_reset();
    req0_op = 6'd0; req0_rs1 = 7; req0_imm = 1;
    req1_op = 6'd10; req1_rs1 = 10; req1_rs2 = 3;
    req0_valid = 1'b1; req1_valid = 1'b1;
    repeat (10) @(posedge clk);
    #1 req0_valid = 1'b0; req1_valid = 1'b0;
    @(negedge clk);
    n_checks++;
    if (perf_conflict !== 32'd10) begin
      n_errors++; $display("FAIL perf_conflict got=%0d exp=10", perf_conflict);
    end
    n_checks++;
    if ((perf_grant0 + perf_grant1) !== 32'd10) begin
      n_errors++; $display("FAIL perf_grants got=%0d exp=10", perf_grant0 + perf_grant1);
    end
    repeat (3) @(posedge clk);
    #1;
  endtask
`endif

  task automatic test_final_drain();
    repeat (2) @(posedge clk);
    #1;
    n_checks++;
    if ((q0.size() != 0) || (q1.size() != 0)) begin
      n_errors++; $display("FAIL final_queues got=%0d/%0d exp=0/0", q0.size(), q1.size());
    end
  endtask

  initial begin
    alu_result = '0;
    test_reset();
    test_single();
    test_contention();
    test_backpressure();
    test_illegal();
    test_reset_midflight();
`ifdef CORE_ALU_ARB_PERF_EN
    test_perf();
`endif
    test_final_drain();
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule

// File: doc/core_alu_arbiter.md
Name: core_alu_arbiter

Overview:
- Shares the single registered integer ALU (one-hot op strobes; RS1/RS2/IMM in; RESULT registered one cycle later) between two requesters: req0 = execute stage, req1 = load/store address generator.
- Round-robin arbitration, valid/ready handshake on each request and response channel, in-flight ownership tracking, and a per-requester response FIFO so results are never lost when a consumer stalls.

Parameters:
- NOPS, 35, number of ALU op strobes; op index order: ADDI0 SLTI1 SLTIU2 XORI3 ORI4 ANDI5 SLLI6 SRLI7 SRAI8 ADD9 SUB10 SLL11 SLT12 SLTU13 XOR14 SRL15 SRA16 OR17 AND18 BEQ19 BNE20 BLT21 BGE22 BLTU23 BGEU24 LB25 LH26 LW27 LBU28 LHU29 SB30 SH31 SW32 FLW33 FSW34
- OPW, 6, op index width
- RESP_DEPTH, 3, response FIFO entries per requester (minimum 2)

Ports:
- CLK  in  1  clock; single clock domain, rising edge
- RST_N  in  1  reset, asynchronous assert, active-low
- REQn_VALID  in  1  request valid (n=0,1)
- REQn_READY  out  1  request accepted when VALID&READY
- REQn_OP  in  OPW  op index
- REQn_RS1 / REQn_RS2 / REQn_IMM  in  32 each  operands
- RESPn_VALID  out  1  response FIFO head valid
- RESPn_READY  in  1  consumer pops head when VALID&READY
- RESPn_DATA  out  32  FIFO head result
- ALU_OP  out  NOPS  one-hot strobes, bit k wired to op k
- ALU_RS1 / ALU_RS2 / ALU_IMM  out  32 each  operands to ALU
- ALU_RESULT  in  32  ALU registered RESULT

Behaviour:
- Reset (async, RST_N low): REQn_READY=0, RESPn_VALID=0, RESPn_DATA=0, FIFOs empty, in-flight cleared, RR pointer=0. ALU_OP=0 and ALU_RS1/RS2/IMM=0 while no grant. Results arriving in the first cycle after deassertion are discarded.
- Occupancy: occ_n = fifo_count_n + (inflight_valid && inflight_id==n). Eligible_n = (occ_n < RESP_DEPTH). A pop in the same cycle does not create credit.
- REQn_READY = eligible_n && (other requester not VALID&eligible || ptr==n). Combinational from registered state and the other VALID only; no dependence on RESPn_READY.
- Grant cycle N: ALU_OP = onehot(REQn_OP) and operands muxed from requester n. If OP >= NOPS: ALU_OP=0 (ALU yields 0), still returned as a normal response. No grant: all ALU outputs 0.
- On grant: inflight_valid<=1, inflight_id<=n, ptr<=~n. With no grant: inflight_valid<=0 and ptr is held.
- Cycle N+1: if inflight_valid, ALU_RESULT is pushed into FIFO inflight_id at the edge ending N+1. RESPn_VALID rises in N+2. Fixed request-to-response latency 2 cycles.
- Push and pop in the same cycle are both honoured; count is unchanged. Push never finds a full FIFO, guaranteed by the occupancy rule. Pointers wrap modulo RESP_DEPTH.
- Throughput: one grant per cycle total. A single requester with an always-ready consumer sustains 1/cycle at RESP_DEPTH>=3; at RESP_DEPTH=2 it sustains 2 grants per 3 cycles.
- Responses to each requester return in request order.

Optional Feature:
- CORE_ALU_ARB_PERF_EN defined: adds outputs PERF_GRANT0, PERF_GRANT1 and PERF_CONFLICT (32 bits each).
  - PERF_GRANTn counts grants to requester n.
  - PERF_CONFLICT counts cycles with both VALID and both eligible.
  - Counters saturate at 32'hFFFFFFFF and reset to 0.
- Undefined: these ports and counters do not exist; all other behaviour is identical.

Test Plan:
- Single grant: REQ0 VALID, OP=9 (ADD), RS1=5, RS2=7 at cycle 0 -> ALU_OP bit9 high in cycle 0 only; RESP0_VALID=1, DATA=12 in cycle 2.
- Contention: both VALID every cycle with RESPn_READY=1, req0 ADDI IMM=1, req1 SUB 10-3, from reset -> grants alternate 0,1,0,1; RESP0 DATA=RS1+1, RESP1 DATA=7 two cycles after each grant.
- Backpressure: req1 back-to-back SW address RS1=0x1000, IMM=4,8,12, RESP1_READY=0 -> exactly 3 accepted, REQ1_READY=0 afterwards. Raising READY drains 0x1004, 0x1008, 0x100C in order, then READY returns.
- Illegal op: REQ0_OP=40 -> ALU_OP=0 in the grant cycle; RESP0 DATA=0 at cycle 2.
- Reset mid-flight: assert RST_N low the cycle after a grant -> RESPn_VALID=0 immediately; no response emerges after release.
- With CORE_ALU_ARB_PERF_EN: contention run of 10 cycles -> PERF_CONFLICT=10 and PERF_GRANT0+PERF_GRANT1=10.
